// File: rtl/loa_arbiter_if.sv
// Request/response bundle between two requesters and the lower-part-OR adder
// arbiter; the arbiter takes the slave side.
interface loa_arbiter_if #(
    parameter int N = 8
);
    logic [1:0]     req_valid;
    logic [2*N-1:0] req_a;
    logic [2*N-1:0] req_b;
    logic [1:0]     req_ready;
    logic           rsp_valid;
    logic           rsp_ready;
    logic           rsp_id;
    logic [N:0]     rsp_sum;
    logic [N:0]     rsp_exact;
    logic           rsp_err;
    logic           busy;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_exact, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_exact, rsp_err, busy
    );
endinterface

// File: rtl/loa_arbiter.sv
// Two-requester round-robin arbiter feeding a lower-part-OR approximate adder;
// returns the approximate sum, the exact sum and their mismatch flag.
module loa_arbiter #(
    parameter int N   = 8,
    parameter int LPL = 4
) (
    input  logic        clk,
    input  logic        rst,
    loa_arbiter_if.slave bus
);
    localparam int UPL = N - LPL;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t         state, state_next;
    logic           last_grant;
    logic [1:0]     grant;
    logic           grant_id;
    logic           accept;
    logic [N-1:0]   a_q, b_q;
    logic           id_q;
    logic [N:0]     sum_q, exact_q;
    logic           err_q;
    logic [UPL:0]   upper_sum;
    logic [N:0]     approx_sum, exact_sum;

    // Grant is gated by rst so req_ready is 0 the moment reset is raised.
    // NOTE: every variable gets a default before the case, so no latch is inferred.
    always_comb begin
        grant = 2'b00;
        if (state == IDLE && !rst) begin
            case (bus.req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    assign grant_id = grant[1];
    assign accept   = |(grant & bus.req_valid);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (bus.rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign upper_sum  = {1'b0, a_q[N-1:LPL]} + {1'b0, b_q[N-1:LPL]};
    assign approx_sum = {upper_sum, a_q[LPL-1:0] | b_q[LPL-1:0]};
    assign exact_sum  = {1'b0, a_q} + {1'b0, b_q};

    // NOTE: the datapath registers are reset too, because they drive outputs that must read 0 in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
            a_q        <= '0;
            b_q        <= '0;
            id_q       <= 1'b0;
            sum_q      <= '0;
            exact_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            if (accept) begin
                last_grant <= grant_id;
                id_q       <= grant_id;
                a_q        <= grant_id ? bus.req_a[2*N-1:N] : bus.req_a[N-1:0];
                b_q        <= grant_id ? bus.req_b[2*N-1:N] : bus.req_b[N-1:0];
            end
            if (state == EXEC) begin
                sum_q   <= approx_sum;
                exact_q <= exact_sum;
                err_q   <= (approx_sum != exact_sum);
            end
        end
    end

    // Result registers only load in EXEC, so they hold steady across RESP back-pressure.
    assign bus.req_ready = grant;
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_id    = id_q;
    assign bus.rsp_sum   = sum_q;
    assign bus.rsp_exact = exact_q;
    assign bus.rsp_err   = err_q;
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_loa_arbiter.sv
// Self-checking bench for loa_arbiter: directed vectors, arbitration and reset
// corner cases, and randomized operations against an arithmetic reference.
module tb_loa_arbiter;
    localparam int N = 8;
    localparam int L = 4;

    typedef struct {
        logic [1:0] vmask;
        logic [7:0] a;
        logic [7:0] b;
        int         exp_id;
        logic [8:0] exp_sum;
        logic [8:0] exp_exact;
        logic       exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;
    int   both_ready_seen = 0;
    int   model_last = 1;

    always #5 clk = ~clk;

    loa_arbiter_if #(.N(N)) bus ();
    loa_arbiter #(.N(N), .LPL(L)) dut (.clk(clk), .rst(rst), .bus(bus));

    always @(negedge clk) if (bus.req_ready == 2'b11) both_ready_seen++;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference: upper halves added as plain integers, lower halves OR-ed.
    function automatic int model_sum(input int a, input int b);
        int up;
        up = (a >> L) + (b >> L);
        return (up << L) | ((a | b) & ((1 << L) - 1));
    endfunction

    function automatic int model_grant(input logic [1:0] vmask);
        if (vmask == 2'b01) return 0;
        if (vmask == 2'b10) return 1;
        return (model_last == 1) ? 0 : 1;
    endfunction

    task automatic set_ops(input logic [7:0] a0, input logic [7:0] b0,
                           input logic [7:0] a1, input logic [7:0] b1);
        bus.req_a = {a1, a0};
        bus.req_b = {b1, b0};
    endtask

    task automatic run_op(input logic [1:0] vmask, input int stall, input bit hold,
                          output int gid, output logic [N:0] sum, output logic [N:0] exact,
                          output logic err, output logic id);
        int n;
        gid = -1; sum = '0; exact = '0; err = 1'b0; id = 1'b0;
        bus.req_valid = vmask;
        bus.rsp_ready = 1'b0;
        #1;
        n = 0;
        while ((bus.req_ready & bus.req_valid) == 2'b00 && n < 20) begin
            cyc();
            n++;
        end
        if (n >= 20) begin
            check("accept_timeout", 1, 0);
            return;
        end
        gid = bus.req_ready[1] ? 1 : 0;
        cyc();
        if (!hold) bus.req_valid = 2'b00;
        #1;
        check("exec_rsp_valid_low", bus.rsp_valid, 0);
        check("exec_busy", bus.busy, 1);
        check("exec_req_ready", bus.req_ready, 0);
        cyc();
        check("rsp_valid_at_t2", bus.rsp_valid, 1);
        sum = bus.rsp_sum; exact = bus.rsp_exact; err = bus.rsp_err; id = bus.rsp_id;
        for (int k = 0; k < stall; k++) begin
            cyc();
            check("stall_valid", bus.rsp_valid, 1);
            check("stall_sum", bus.rsp_sum, sum);
            check("stall_exact", bus.rsp_exact, exact);
            check("stall_err", bus.rsp_err, err);
            check("stall_id", bus.rsp_id, id);
            check("stall_req_ready", bus.req_ready, 0);
            check("stall_busy", bus.busy, 1);
        end
        bus.rsp_ready = 1'b1;
        cyc();
        bus.rsp_ready = 1'b0;
        #1;
        check("idle_rsp_valid", bus.rsp_valid, 0);
        check("idle_busy", bus.busy, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, bus.req_ready, 0);
        check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        check({tag, "_rsp_id"}, bus.rsp_id, 0);
        check({tag, "_rsp_sum"}, bus.rsp_sum, 0);
        check({tag, "_rsp_exact"}, bus.rsp_exact, 0);
        check({tag, "_rsp_err"}, bus.rsp_err, 0);
        check({tag, "_busy"}, bus.busy, 0);
    endtask

    initial begin
        vec_t       vecs[6];
        int         gid, exp_g, n, a0, b0, a1, b1, ea, eb, stall;
        logic [N:0] sum, exact;
        logic       err, id;
        logic [1:0] vm;

        vecs[0] = '{2'b01, 8'h0F, 8'h01, 0, 9'h00F, 9'h010, 1'b1};
        vecs[1] = '{2'b10, 8'hF0, 8'h10, 1, 9'h100, 9'h100, 1'b0};
        vecs[2] = '{2'b01, 8'hFF, 8'hFF, 0, 9'h1EF, 9'h1FE, 1'b1};
        vecs[3] = '{2'b10, 8'h00, 8'h00, 1, 9'h000, 9'h000, 1'b0};
        vecs[4] = '{2'b01, 8'h35, 8'h4A, 0, 9'h07F, 9'h07F, 1'b0};
        vecs[5] = '{2'b10, 8'h88, 8'h88, 1, 9'h108, 9'h110, 1'b1};

        // Reset with both requesters already asking.
        rst = 1'b1;
        bus.req_valid = 2'b11;
        bus.rsp_ready = 1'b0;
        set_ops(8'h0F, 8'h01, 8'hF0, 8'h10);
        #12;
        check_reset_outputs("reset");
        cyc();
        rst = 1'b0;

        // Both held high from reset: strict alternation starting at requester 0.
        for (int i = 0; i < 4; i++) begin
            run_op(2'b11, 0, 1'b1, gid, sum, exact, err, id);
            check("tie_grant", gid, i % 2);
            check("tie_id", id, i % 2);
            check("tie_sum", sum, (i % 2) ? 9'h100 : 9'h00F);
            check("tie_exact", exact, (i % 2) ? 9'h100 : 9'h010);
            model_last = i % 2;
        end
        bus.req_valid = 2'b00;
        cyc();

        // Directed vectors; the idle requester carries complemented operands.
        foreach (vecs[i]) begin
            if (vecs[i].exp_id == 0) set_ops(vecs[i].a, vecs[i].b, ~vecs[i].a, ~vecs[i].b);
            else                     set_ops(~vecs[i].a, ~vecs[i].b, vecs[i].a, vecs[i].b);
            run_op(vecs[i].vmask, 0, 1'b0, gid, sum, exact, err, id);
            check("vec_grant", gid, vecs[i].exp_id);
            check("vec_id", id, vecs[i].exp_id);
            check("vec_sum", sum, vecs[i].exp_sum);
            check("vec_exact", exact, vecs[i].exp_exact);
            check("vec_err", err, vecs[i].exp_err);
            model_last = vecs[i].exp_id;
        end

        // Back-pressure: five cycles of rsp_ready low.
        set_ops(8'h0F, 8'h01, 8'h00, 8'h00);
        run_op(2'b01, 5, 1'b0, gid, sum, exact, err, id);
        check("bp_sum", sum, 9'h00F);
        check("bp_exact", exact, 9'h010);
        check("bp_err", err, 1);
        model_last = 0;

        // Randomized traffic against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            a0 = $urandom_range(0, 255); b0 = $urandom_range(0, 255);
            a1 = $urandom_range(0, 255); b1 = $urandom_range(0, 255);
            vm = 2'($urandom_range(1, 3));
            stall = $urandom_range(0, 3);
            set_ops(8'(a0), 8'(b0), 8'(a1), 8'(b1));
            exp_g = model_grant(vm);
            ea = (exp_g == 1) ? a1 : a0;
            eb = (exp_g == 1) ? b1 : b0;
            run_op(vm, stall, 1'b0, gid, sum, exact, err, id);
            check("rnd_grant", gid, exp_g);
            check("rnd_id", id, exp_g);
            check("rnd_sum", sum, model_sum(ea, eb));
            check("rnd_exact", exact, ea + eb);
            check("rnd_err", err, (model_sum(ea, eb) != ea + eb) ? 1 : 0);
            model_last = exp_g;
        end

        // Reset mid-EXEC: requester 0 accepted, then aborted.
        set_ops(8'hFF, 8'hFF, 8'h11, 8'h22);
        bus.req_valid = 2'b01;
        bus.rsp_ready = 1'b0;
        #1;
        n = 0;
        while (bus.req_ready[0] !== 1'b1 && n < 20) begin
            cyc();
            n++;
        end
        check("abort_accept_seen", bus.req_ready[0], 1);
        cyc();
        check("abort_in_exec", bus.busy, 1);
        bus.req_valid = 2'b11;
        rst = 1'b1;
        #1;
        check_reset_outputs("abort");
        cyc();
        cyc();
        bus.req_valid = 2'b00;
        bus.rsp_ready = 1'b1;
        rst = 1'b0;
        n = 0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            if (bus.rsp_valid) n++;
        end
        check("abort_no_response", n, 0);
        model_last = 1;
        run_op(2'b11, 0, 1'b0, gid, sum, exact, err, id);
        check("abort_tie_grant", gid, model_grant(2'b11));
        check("abort_tie_sum", sum, model_sum(8'hFF, 8'hFF));

        check("req_ready_never_both", both_ready_seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/loa_arbiter.md
LOA_ARBITER -- requirements
Module: loa_arbiter

Interface
REQ-001 SHALL have parameter N, default 8: operand width.
REQ-002 SHALL have parameter LPL, default 4: approximate (OR) lower-part width; UPL = N-LPL; legal range 1 <= LPL <= N-1.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  2  per-requester request valid; bit r = requester r.
REQ-006 SHALL have port req_a  input  2*N  operand A; requester r in bits [r*N +: N].
REQ-007 SHALL have port req_b  input  2*N  operand B; same packing as req_a.
REQ-008 SHALL have port req_ready  output  2  per-requester accept; at most one bit high.
REQ-009 SHALL have port rsp_valid  output  1  response valid.
REQ-010 SHALL have port rsp_ready  input  1  response consumer ready.
REQ-011 SHALL have port rsp_id  output  1  requester index of the response.
REQ-012 SHALL have port rsp_sum  output  N+1  lower-part-OR approximate sum.
REQ-013 SHALL have port rsp_exact  output  N+1  exact A+B.
REQ-014 SHALL have port rsp_err  output  1  high when rsp_sum != rsp_exact.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE; one operation in flight at a time.
REQ-017 SHALL drive req_ready only in IDLE, to the granted requester only; accept = req_valid[r] & req_ready[r].
REQ-018 SHALL arbitrate round-robin: single valid requester wins; both valid -> requester != last_grant wins.
REQ-019 SHALL update last_grant only on accept; last_grant reset value = 1 (requester 0 wins first tie).
REQ-020 SHALL on accept latch selected A, B and id, and move IDLE -> EXEC.
REQ-021 SHALL in EXEC compute and register: sum[LPL-1:0] = A|B lower bits; sum[N:LPL] = A[N-1:LPL]+B[N-1:LPL] with zero carry-in, carry-out to sum[N]; exact = A+B (N+1 bits); err = (sum != exact); move to RESP.
REQ-022 SHALL assert rsp_valid in RESP only; accept on cycle T -> rsp_valid first high in cycle T+2.
REQ-023 SHALL hold rsp_valid, rsp_id, rsp_sum, rsp_exact, rsp_err stable while rsp_valid & !rsp_ready.
REQ-024 SHALL on rsp_valid & rsp_ready move RESP -> IDLE; minimum throughput one op per 3 cycles.
REQ-025 SHALL ignore req_valid changes outside IDLE; a dropped req_valid in IDLE is never granted.
REQ-026 SHALL produce no X on outputs for any legal input.

Reset
REQ-027 SHALL on rst high immediately force state IDLE, last_grant = 1, and all outputs to 0 (req_ready 0, rsp_valid 0, rsp_id 0, rsp_sum 0, rsp_exact 0, rsp_err 0, busy 0).
REQ-028 SHALL abort any in-flight operation on reset mid-EXEC or mid-RESP without producing a response.
REQ-029 SHALL resume arbitration on the first rising clk edge after rst deasserts.

Verification
REQ-030 SHALL test req0 A=0x0F B=0x01 -> rsp_id 0, rsp_sum 0x00F, rsp_exact 0x010, rsp_err 1, rsp_valid at T+2.
REQ-031 SHALL test req1 A=0xF0 B=0x10 -> rsp_id 1, rsp_sum 0x100, rsp_exact 0x100, rsp_err 0.
REQ-032 SHALL test A=0xFF B=0xFF -> rsp_sum 0x1EF, rsp_exact 0x1FE, rsp_err 1.
REQ-033 SHALL test both req_valid held high from reset for 4 ops -> grant order 0,1,0,1; req_ready never 2'b11.
REQ-034 SHALL test rsp_ready low 5 cycles in RESP -> outputs stable, req_ready 2'b00, busy 1; completes on rsp_ready high.
REQ-035 SHALL test rst pulse during EXEC -> outputs 0 immediately, no rsp_valid afterwards, next tie granted to requester 0.
